// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: shared widths, halt word and fetch state encoding
package instruction_fetch_pkg;
  localparam int FETCH_ADDR_W = 10;
  localparam int FETCH_DATA_W = 32;
  localparam logic [FETCH_DATA_W-1:0] FETCH_HALT_WORD = 32'hFFFF_FFFF;
  typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_HALT} fetch_state_e;
endpackage

// File: rtl/instruction_fetch_fifo.sv
// instruction_fetch_fifo: DEPTH-entry first-word-fall-through FIFO with single-edge flush
module instruction_fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 42,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic          valid_o,
  output logic [CW-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  // storage needs no reset: the head is only visible while count is non-zero
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q] <= din_i;
  // pointers and occupancy; flush empties the buffer in one edge
  always_ff @(posedge clk)
    if (reset || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= inc(wr_q);
      if (pop_i) rd_q <= inc(rd_q);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  assign valid_o = cnt_q != '0;
  assign dout_o  = valid_o ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: pc master for instruction memory, buffers {pc, word} to decode; HALT_DETECT_EN enables halt-word stop
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int DATA_W = FETCH_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] instruction,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [DATA_W-1:0] ins_out,
  output logic [ADDR_W-1:0] ins_pc,
  output logic              halted
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = CW + 1;
  fetch_state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, inflight_pc_q;
  logic inflight_q, push, pop, halt_push, room, issue;
  logic [CW-1:0] count;
  logic [OW-1:0] occ;
  logic [ADDR_W+DATA_W-1:0] head;
  assign pop  = ins_valid & ins_ready;
  assign push = inflight_q & ~redirect_valid & (state_q != ST_HALT);
`ifdef HALT_DETECT_EN
  assign halt_push = push & (instruction == DATA_W'(FETCH_HALT_WORD));
  assign halted    = state_q == ST_HALT;
`else
  assign halt_push = 1'b0;
  assign halted    = 1'b0;
`endif
  assign occ   = OW'(count) + OW'(push) - OW'(pop);
  assign room  = occ < OW'(DEPTH);
  assign issue = ~redirect_valid & ~halt_push & (state_q != ST_HALT) & room;
  // next fetch address and state; redirect outranks halt and stall
  always_comb begin
    pc_d    = redirect_valid ? redirect_pc : issue ? pc_q + 1'b1 : pc_q;
    state_d = redirect_valid ? ST_RUN :
              (halt_push || state_q == ST_HALT) ? ST_HALT :
              issue ? ST_RUN : ST_STALL;
  end
  // fetch registers: the word returning next cycle belongs to the pc held now
  always_ff @(posedge clk)
    if (reset) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= issue;
      inflight_pc_q <= pc_q;
    end
  instruction_fetch_fifo #(.DEPTH(DEPTH), .W(ADDR_W + DATA_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (redirect_valid),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ({inflight_pc_q, instruction}),
    .dout_o  (head),
    .valid_o (ins_valid),
    .count_o (count)
  );
  assign pc = pc_q;
  assign {ins_pc, ins_out} = head;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed scenarios plus randomized ready/redirect against an in-order stream model
module tb_instruction_fetch;
  localparam int AW = 10;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [AW-1:0] pc;
  logic [DW-1:0] instruction;
  logic redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic ins_valid;
  logic ins_ready = 1'b0;
  logic [DW-1:0] ins_out;
  logic [AW-1:0] ins_pc;
  logic halted;
  logic [DW-1:0] mem [1024];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) instruction <= mem[pc];

  instruction_fetch #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(10'd0), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .pc(pc), .instruction(instruction),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_out(ins_out),
    .ins_pc(ins_pc), .halted(halted)
  );

  task automatic restart();
    @(negedge clk);
    reset = 1'b1;
    redirect_valid = 1'b0;
    ins_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_show(input logic [AW-1:0] a, output bit found);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      found = ins_valid === 1'b1 && ins_pc === a;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++; if (ins_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", ins_valid); end
    total++; if (pc !== 10'd0) begin bad++; $display("FAIL reset_pc: got %0d want 0", pc); end
    total++; if (ins_out !== 32'd0) begin bad++; $display("FAIL reset_out: got %h want 0", ins_out); end
    total++; if (ins_pc !== 10'd0) begin bad++; $display("FAIL reset_ins_pc: got %0d want 0", ins_pc); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted: got %b want 0", halted); end
  endtask

  task automatic test_stream();
    restart();
    @(negedge clk);
    total++; if (ins_valid !== 1'b0) begin bad++; $display("FAIL stream_first: valid %b want 0", ins_valid); end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      total++;
      if (ins_valid !== 1'b1 || ins_pc !== AW'(i) || ins_out !== mem[i]) begin
        bad++;
        $display("FAIL stream[%0d]: got v=%b pc=%0d out=%h want v=1 pc=%0d out=%h", i, ins_valid, ins_pc, ins_out, i, mem[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit f;
    restart();
    wait_show(10'd4, f);
    total++; if (!f) begin bad++; $display("FAIL bp_reach: ins_pc 4 not seen, got %0d", ins_pc); end
    ins_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (ins_valid !== 1'b1 || ins_pc !== 10'd4 || ins_out !== mem[4]) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got v=%b pc=%0d out=%h want v=1 pc=4 out=%h", i, ins_valid, ins_pc, ins_out, mem[4]);
      end
    end
    total++; if (pc !== 10'd6) begin bad++; $display("FAIL bp_pc_stop: got %0d want 6", pc); end
    ins_ready = 1'b1;
    for (int j = 1; j < 4; j++) begin
      @(negedge clk);
      total++;
      if (ins_valid !== 1'b1 || ins_pc !== AW'(4 + j) || ins_out !== mem[4 + j]) begin
        bad++;
        $display("FAIL bp_resume[%0d]: got v=%b pc=%0d want v=1 pc=%0d", j, ins_valid, ins_pc, 4 + j);
      end
    end
  endtask

  task automatic test_redirect(input logic [AW-1:0] start, input logic [AW-1:0] target);
    bit f;
    restart();
    wait_show(start, f);
    total++; if (!f) begin bad++; $display("FAIL redir_reach: ins_pc %0d not seen, got %0d", start, ins_pc); end
    redirect_valid = 1'b1;
    redirect_pc = target;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      redirect_valid = 1'b0;
      total++; if (ins_valid !== 1'b0) begin bad++; $display("FAIL redir_gap[%0d]: valid %b pc=%0d want 0", i, ins_valid, ins_pc); end
    end
    for (int j = 0; j < 4; j++) begin
      logic [AW-1:0] e;
      e = target + AW'(j);
      @(negedge clk);
      total++;
      if (ins_valid !== 1'b1 || ins_pc !== e || ins_out !== mem[e]) begin
        bad++;
        $display("FAIL redir_seq[%0d]: got v=%b pc=%0d out=%h want v=1 pc=%0d out=%h", j, ins_valid, ins_pc, ins_out, e, mem[e]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit f;
    restart();
    wait_show(10'd3, f);
    total++; if (!f) begin bad++; $display("FAIL rmid_reach: ins_pc 3 not seen, got %0d", ins_pc); end
    ins_ready = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (ins_valid !== 1'b0 || pc !== 10'd0 || ins_pc !== 10'd0 || ins_out !== 32'd0) begin
      bad++;
      $display("FAIL rmid_clear: got v=%b pc=%0d ins_pc=%0d out=%h want all 0", ins_valid, pc, ins_pc, ins_out);
    end
    reset = 1'b0;
    ins_ready = 1'b1;
    @(negedge clk);
    total++; if (ins_valid !== 1'b0) begin bad++; $display("FAIL rmid_first: valid %b want 0", ins_valid); end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      total++;
      if (ins_valid !== 1'b1 || ins_pc !== AW'(j) || ins_out !== mem[j]) begin
        bad++;
        $display("FAIL rmid_seq[%0d]: got v=%b pc=%0d want v=1 pc=%0d", j, ins_valid, ins_pc, j);
      end
    end
  endtask

  task automatic test_halt();
    bit f;
    mem[7] = 32'hFFFF_FFFF;
    restart();
    wait_show(10'd7, f);
    total++; if (!f) begin bad++; $display("FAIL halt_reach: ins_pc 7 not seen, got %0d", ins_pc); end
    total++; if (ins_out !== 32'hFFFF_FFFF) begin bad++; $display("FAIL halt_word: got %h want ffffffff", ins_out); end
`ifdef HALT_DETECT_EN
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_flag: got %b want 1", halted); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (ins_valid !== 1'b0 || halted !== 1'b1) begin
        bad++;
        $display("FAIL halt_idle[%0d]: got v=%b pc=%0d halted=%b want v=0 halted=1", i, ins_valid, ins_pc, halted);
      end
    end
    redirect_valid = 1'b1;
    redirect_pc = 10'd0;
    @(negedge clk);
    redirect_valid = 1'b0;
    total++; if (halted !== 1'b0 || ins_valid !== 1'b0) begin bad++; $display("FAIL halt_release: got halted=%b v=%b want 0 0", halted, ins_valid); end
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      total++;
      if (ins_valid !== 1'b1 || ins_pc !== AW'(j)) begin
        bad++;
        $display("FAIL halt_restart[%0d]: got v=%b pc=%0d want v=1 pc=%0d", j, ins_valid, ins_pc, j);
      end
    end
`else
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_flag: got %b want 0", halted); end
    @(negedge clk);
    total++;
    if (ins_valid !== 1'b1 || ins_pc !== 10'd8 || halted !== 1'b0) begin
      bad++;
      $display("FAIL halt_passthru: got v=%b pc=%0d halted=%b want v=1 pc=8 halted=0", ins_valid, ins_pc, halted);
    end
`endif
    mem[7] = 32'd7;
  endtask

  task automatic test_random();
    logic [AW-1:0] exp_pc;
    int gap;
    restart();
    @(negedge clk);
    exp_pc = '0;
    gap = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      total++;
      if (ins_valid === 1'b1) begin
        gap = 0;
        if (ins_pc !== exp_pc || ins_out !== mem[exp_pc]) begin
          bad++;
          $display("FAIL rnd[%0d]: got pc=%0d out=%h want pc=%0d out=%h", c, ins_pc, ins_out, exp_pc, mem[exp_pc]);
        end
      end else begin
        gap++;
        if (gap > 3) begin bad++; $display("FAIL rnd_gap[%0d]: no valid for %0d cycles, want <=3", c, gap); end
      end
      ins_ready = $urandom_range(0, 99) < 70;
      redirect_valid = $urandom_range(0, 99) < 4;
      redirect_pc = AW'($urandom_range(0, 1023));
      if (ins_valid === 1'b1 && ins_ready) exp_pc = exp_pc + 1'b1;
      if (redirect_valid) begin
        exp_pc = redirect_pc;
        gap = 0;
      end
    end
    redirect_valid = 1'b0;
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL rnd_halted: got %b want 0", halted); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect(10'd10, 10'd100);
    test_redirect(10'd20, 10'd1022);
    test_reset_mid();
    test_halt();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
